event_encoder_16_4: RTL and testbench



---
 rtl/event_encoder_16_4_if.sv | 28 ++
 rtl/event_encoder_16_4.sv | 109 ++++++++++
 tb/tb_event_encoder_16_4.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/event_encoder_16_4_if.sv
// event_encoder_16_4_if
// Groups the request side (en, clr, req) and the code output side
// (code, valid, ready, plus the pend/overflow/busy status) of the
// 16-to-4 event encoder into one bundle.
//   master : drives en, clr, req, ready; observes code, valid, pend,
//            overflow, busy (event source / consumer side)
//   slave  : the encoder itself
interface event_encoder_16_4_if;
    logic        en;
    logic        clr;
    logic [15:0] req;
    logic        ready;
    logic [3:0]  code;
    logic        valid;
    logic [15:0] pend;
    logic        overflow;
    logic        busy;

    modport master (
        output en, clr, req, ready,
        input  code, valid, pend, overflow, busy
    );

    modport slave (
        input  en, clr, req, ready,
        output code, valid, pend, overflow, busy
    );
endinterface

// File: rtl/event_encoder_16_4.sv
// event_encoder_16_4
// Captures 16 level-sampled request lines into a pending register and
// hands their indices out one per cycle, highest index first, through a
// registered valid/ready output stage. A request on an index that is
// still outstanding (pending, or held unconsumed in the output stage)
// sets a sticky overflow flag instead of being queued twice.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears all state
//   bus    : slave side of event_encoder_16_4_if
//            en/clr/req/ready in, code/valid/pend/overflow/busy out
module event_encoder_16_4 (
    input  logic                 clk,
    input  logic                 reset,
    event_encoder_16_4_if.slave  bus
);

    logic [15:0] pend_q, pend_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;

    logic        take;
    logic        load;
    logic [3:0]  sel;
    logic [15:0] loadMask;
    logic [15:0] reqEn;
    logic [15:0] dupMask;

    // A transfer happens whenever the held code is accepted; the stage can
    // be refilled whenever it is empty or being emptied this same cycle,
    // which is what lets codes stream out back-to-back.
    assign take  = valid_q & bus.ready;
    assign load  = (~valid_q | bus.ready) & (|pend_q);
    assign reqEn = bus.en ? bus.req : 16'h0000;

    // Fixed-priority selection of the highest pending index. Scanning
    // upwards lets the last hit (the highest bit) win.
    always_comb begin
        sel = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (pend_q[i]) begin
                sel = 4'(i);
            end
        end
    end

    assign loadMask = load ? (16'h0001 << sel) : 16'h0000;

    // An index is outstanding if it is still pending and not leaving the
    // pending register now, or if it sits in the output stage and is not
    // being consumed now. Requests on such an index are duplicates; the
    // index being loaded or taken this cycle counts as free again.
    always_comb begin
        dupMask = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            dupMask[i] = (pend_q[i] & ~loadMask[i])
                       | (valid_q & ~take & (code_q == 4'(i)));
        end
    end

    // Next-state logic. Clear wins over everything, including a pending
    // handshake. Otherwise the loaded bit leaves the pending register,
    // fresh non-duplicate requests join it (a request on the bit being
    // loaded is kept), and duplicates only raise the sticky flag.
    always_comb begin
        pend_d  = pend_q;
        code_d  = code_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            pend_d  = 16'h0000;
            code_d  = 4'd0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            pend_d = (pend_q & ~loadMask) | (reqEn & ~dupMask);
            ovf_d  = ovf_q | (|(reqEn & dupMask));
            if (load) begin
                code_d  = sel;
                valid_d = 1'b1;
            end else if (take) begin
                valid_d = 1'b0;
            end
        end
    end

    // State registers with asynchronous reset back to the empty state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q  <= 16'h0000;
            code_q  <= 4'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.code     = code_q;
    assign bus.valid    = valid_q;
    assign bus.pend     = pend_q;
    assign bus.overflow = ovf_q;
    assign bus.busy     = valid_q | (|pend_q);

endmodule

// File: tb/tb_event_encoder_16_4.sv
// tb_event_encoder_16_4
// Self-checking bench for event_encoder_16_4: a table of directed
// vectors, hand-written multi-cycle sequences (backpressure/overflow,
// async reset mid-burst, consume-and-re-request) and a randomized run
// compared against an event-level reference model.
module tb_event_encoder_16_4;

    logic clk = 1'b0;
    logic reset = 1'b0;

    event_encoder_16_4_if bus ();

    event_encoder_16_4 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int totalCount = 0;
    int badCount   = 0;

    typedef struct {
        logic        en;
        logic        clr;
        logic [15:0] req;
        logic        ready;
        logic        expValid;
        logic [3:0]  expCode;
        logic [15:0] expPend;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    // Reference model: a set of outstanding event indices plus the one
    // event currently offered to the consumer.
    bit   mPend[16];
    bit   mValid;
    int   mCode;
    bit   mOvf;

    function automatic logic [15:0] modelPendBits();
        logic [15:0] r;
        r = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            if (mPend[i]) r = r + 16'(1 << i);
        end
        return r;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 16; i++) mPend[i] = 1'b0;
        mValid = 1'b0;
        mCode  = 0;
        mOvf   = 1'b0;
    endtask

    task automatic modelEdge(input bit e, input bit c, input logic [15:0] r, input bit rd);
        bit newPend[16];
        bit took;
        bit free;
        int top;
        bit outstanding;
        if (c) begin
            modelClear();
            return;
        end
        took = mValid && rd;
        free = !mValid || rd;
        top  = -1;
        for (int i = 15; i >= 0; i--) begin
            if (mPend[i]) begin
                top = i;
                break;
            end
        end
        for (int i = 0; i < 16; i++) newPend[i] = mPend[i];
        if (free && top >= 0) newPend[top] = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (e && r[i]) begin
                outstanding = (mPend[i] && !(free && top == i))
                           || (mValid && mCode == i && !took);
                if (outstanding) mOvf = 1'b1;
                else newPend[i] = 1'b1;
            end
        end
        if (free && top >= 0) begin
            mValid = 1'b1;
            mCode  = top;
        end else if (took) begin
            mValid = 1'b0;
        end
        for (int i = 0; i < 16; i++) mPend[i] = newPend[i];
    endtask

    // Drive one cycle of inputs, advance the model, and stop #1 after the
    // edge so outputs are sampled away from it.
    task automatic applyStimulus(input bit e, input bit c, input logic [15:0] r, input bit rd);
        bus.en    = e;
        bus.clr   = c;
        bus.req   = r;
        bus.ready = rd;
        modelEdge(e, c, r, rd);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expValid, input logic [3:0] expCode,
                               input logic [15:0] expPend, input logic expOvf);
        logic expBusy;
        expBusy = expValid | (|expPend);
        totalCount++;
        if (bus.valid !== expValid || bus.code !== expCode || bus.pend !== expPend
            || bus.overflow !== expOvf || bus.busy !== expBusy) begin
            badCount++;
            $display("[TB] FAIL %s: got valid=%b code=%0d pend=%h ovf=%b busy=%b, want valid=%b code=%0d pend=%h ovf=%b busy=%b",
                     name, bus.valid, bus.code, bus.pend, bus.overflow, bus.busy,
                     expValid, expCode, expPend, expOvf, expBusy);
        end
    endtask

    task automatic resetDut();
        reset     = 1'b1;
        bus.en    = 1'b0;
        bus.clr   = 1'b0;
        bus.req   = 16'h0000;
        bus.ready = 1'b0;
        modelClear();
        #2;
        checkOutput("reset", 1'b0, 4'd0, 16'h0000, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic addVec(input bit e, input bit c, input logic [15:0] r, input bit rd,
                          input bit v, input logic [3:0] cd, input logic [15:0] p, input bit o);
        vec_t x;
        x = '{en: e, clr: c, req: r, ready: rd, expValid: v, expCode: cd, expPend: p, expOvf: o};
        vecs.push_back(x);
    endtask

    initial begin
        #1;
        $display("[TB] event_encoder_16_4 bench start");

        // Directed vectors: single event, burst ordering, enable gating and clear.
        addVec(1, 0, 16'h0020, 1, 0, 4'd0,  16'h0020, 0);
        addVec(1, 0, 16'h0000, 1, 1, 4'd5,  16'h0000, 0);
        addVec(1, 0, 16'h0000, 1, 0, 4'd5,  16'h0000, 0);
        addVec(1, 0, 16'h8421, 1, 0, 4'd5,  16'h8421, 0);
        addVec(1, 0, 16'h0000, 1, 1, 4'd15, 16'h0421, 0);
        addVec(1, 0, 16'h0000, 1, 1, 4'd10, 16'h0021, 0);
        addVec(1, 0, 16'h0000, 1, 1, 4'd5,  16'h0001, 0);
        addVec(1, 0, 16'h0000, 1, 1, 4'd0,  16'h0000, 0);
        addVec(1, 0, 16'h0000, 1, 0, 4'd0,  16'h0000, 0);
        for (int k = 0; k < 4; k++) addVec(0, 0, 16'hFFFF, 1, 0, 4'd0, 16'h0000, 0);
        addVec(1, 0, 16'h00F0, 0, 0, 4'd0,  16'h00F0, 0);
        addVec(1, 0, 16'h00F0, 0, 1, 4'd7,  16'h00F0, 1);
        addVec(1, 1, 16'hFFFF, 1, 0, 4'd0,  16'h0000, 0);
        addVec(0, 0, 16'h0000, 0, 0, 4'd0,  16'h0000, 0);

        resetDut();
        foreach (vecs[k]) begin
            applyStimulus(vecs[k].en, vecs[k].clr, vecs[k].req, vecs[k].ready);
            checkOutput($sformatf("vec%0d", k), vecs[k].expValid, vecs[k].expCode,
                        vecs[k].expPend, vecs[k].expOvf);
        end

        // Backpressure: code 3 held, duplicate bit 3 flags overflow, bit 9 queues.
        resetDut();
        applyStimulus(1, 0, 16'h0008, 0); checkOutput("bp_cap3",   0, 4'd3 - 4'd3, 16'h0008, 0);
        applyStimulus(1, 0, 16'h0000, 0); checkOutput("bp_load3",  1, 4'd3, 16'h0000, 0);
        applyStimulus(1, 0, 16'h0008, 0); checkOutput("bp_dup3",   1, 4'd3, 16'h0000, 1);
        applyStimulus(1, 0, 16'h0200, 0); checkOutput("bp_req9",   1, 4'd3, 16'h0200, 1);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("bp_code9",  1, 4'd9, 16'h0000, 1);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("bp_drain",  0, 4'd9, 16'h0000, 1);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("bp_sticky", 0, 4'd9, 16'h0000, 1);
        applyStimulus(1, 1, 16'h0000, 0); checkOutput("bp_clr",    0, 4'd0, 16'h0000, 0);

        // Async reset after two codes of a full burst have been transferred.
        resetDut();
        applyStimulus(1, 0, 16'hFFFF, 1); checkOutput("ar_cap",  0, 4'd0,  16'hFFFF, 0);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("ar_c15",  1, 4'd15, 16'h7FFF, 0);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("ar_c14",  1, 4'd14, 16'h3FFF, 0);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("ar_c13",  1, 4'd13, 16'h1FFF, 0);
        reset = 1'b1;
        modelClear();
        #2;
        checkOutput("ar_async", 0, 4'd0, 16'h0000, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 16'h0000, 1);
            checkOutput("ar_quiet", 0, 4'd0, 16'h0000, 0);
        end

        // Re-request of code 7 on the very cycle it is consumed.
        resetDut();
        applyStimulus(1, 0, 16'h0080, 0); checkOutput("rr_cap",   0, 4'd0, 16'h0080, 0);
        applyStimulus(1, 0, 16'h0000, 0); checkOutput("rr_hold",  1, 4'd7, 16'h0000, 0);
        applyStimulus(1, 0, 16'h0080, 1); checkOutput("rr_take",  0, 4'd7, 16'h0080, 0);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("rr_again", 1, 4'd7, 16'h0000, 0);
        applyStimulus(1, 0, 16'h0000, 1); checkOutput("rr_done",  0, 4'd7, 16'h0000, 0);

        // Randomized traffic against the reference model.
        resetDut();
        for (int k = 0; k < 600; k++) begin
            logic [15:0] r;
            bit e, c, rd;
            r  = 16'($urandom & $urandom & $urandom);
            e  = ($urandom_range(0, 9) != 0);
            c  = ($urandom_range(0, 39) == 0);
            rd = ($urandom_range(0, 9) < 7);
            applyStimulus(e, c, r, rd);
            checkOutput("rand", mValid, 4'(mCode), modelPendBits(), mOvf);
        end

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
